// File: rtl/reg_resultado_alu.sv
// Registered execute-stage output buffer: captures the adder result, derives the
// RV32I compare/branch flags and hands them downstream through a two-entry skid buffer.
module reg_resultado_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             resta,
  input  logic [WIDTH-1:0] Y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic             menor,
  output logic             menor_u,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cuenta
);

  localparam int ENT_W = WIDTH + 6;

  // Entry layout: {res, zero, neg, carry, ovf, menor, menor_u}
  function automatic logic [ENT_W-1:0] pack_flags(
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic             fresta,
    input logic [WIDTH-1:0] fy
  );
    logic [WIDTH-1:0] b_x;
    logic [WIDTH:0]   suma;
    logic             f_carry, f_ovf, f_menor, f_menor_u;
    b_x       = fb ^ {WIDTH{fresta}};
    suma      = {1'b0, fa} + {1'b0, b_x} + {{WIDTH{1'b0}}, fresta};
    f_carry   = suma[WIDTH];
    if (fresta)
      f_ovf = (fa[WIDTH-1] != fb[WIDTH-1]) && (fy[WIDTH-1] != fa[WIDTH-1]);
    else
      f_ovf = (fa[WIDTH-1] == fb[WIDTH-1]) && (fy[WIDTH-1] != fa[WIDTH-1]);
    f_menor   = fresta & (fy[WIDTH-1] ^ f_ovf);
    f_menor_u = fresta & ~f_carry;
    return {fy, (fy == '0), fy[WIDTH-1], f_carry, f_ovf, f_menor, f_menor_u};
  endfunction

  // Stage p0: flags derived combinationally from the input-side values
  logic [ENT_W-1:0] ent_p0;
  logic             acc_p0;

  assign ent_p0 = pack_flags(a, b, resta, Y);
  assign acc_p0 = in_valid & in_ready;

  // Stage p1: main register (drives outputs) plus one skid entry
  logic [ENT_W-1:0] ent_p1, ent_sk;
  logic             vld_p1, vld_sk;
  logic             main_free, xfer, vld_sk_nxt;

  assign xfer      = vld_p1 & out_ready;
  assign main_free = ~vld_p1 | out_ready;

  always_comb begin
    vld_sk_nxt = vld_sk;
    if (main_free) begin
      if (vld_sk) vld_sk_nxt = acc_p0;
    end else if (acc_p0) begin
      vld_sk_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_p1   <= '0;
      ent_sk   <= '0;
      vld_p1   <= 1'b0;
      vld_sk   <= 1'b0;
      in_ready <= 1'b0;
      cuenta   <= '0;
    end else begin
      vld_sk   <= vld_sk_nxt;
      in_ready <= ~vld_sk_nxt;
      if (xfer) cuenta <= cuenta + CNT_W'(1);
      if (main_free) begin
        if (vld_sk) begin
          ent_p1 <= ent_sk;
          vld_p1 <= 1'b1;
          if (acc_p0) ent_sk <= ent_p0;
        end else if (acc_p0) begin
          ent_p1 <= ent_p0;
          vld_p1 <= 1'b1;
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (acc_p0) begin
        ent_sk <= ent_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign {res, zero, neg, carry, ovf, menor, menor_u} = ent_p1;

endmodule

// File: tb/tb_reg_resultado_alu.sv
// Directed bench for reg_resultado_alu with an expected-result queue checked at the output handshake.
module tb_reg_resultado_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, Y;
  logic        resta, in_valid, in_ready;
  logic [31:0] res;
  logic        zero, neg, carry, ovf, menor, menor_u;
  logic        out_valid, out_ready;
  logic [31:0] cuenta;

  typedef struct packed {
    logic [31:0] res;
    logic zero, neg, carry, ovf, menor, menor_u;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  reg_resultado_alu #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .resta(resta), .Y(Y),
    .in_valid(in_valid), .in_ready(in_ready), .res(res), .zero(zero),
    .neg(neg), .carry(carry), .ovf(ovf), .menor(menor), .menor_u(menor_u),
    .out_valid(out_valid), .out_ready(out_ready), .cuenta(cuenta)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model built from arithmetic, not from the flag equations
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mr, input logic [31:0] my);
    exp_t   e;
    longint sa, sb, r;
    logic [32:0] s;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    r  = mr ? sa - sb : sa + sb;
    s  = {1'b0, ma} + {1'b0, mb};
    e.res     = my;
    e.zero    = (my == 32'd0);
    e.neg     = my[31];
    e.carry   = mr ? (ma >= mb) : s[32];
    e.ovf     = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.menor   = mr && (sa < sb);
    e.menor_u = mr && (ma < mb);
    return e;
  endfunction

  // Scoreboard: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {32'd0, res}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_res", {32'd0, res}, {32'd0, e.res});
        chk("sb_flags", {58'd0, zero, neg, carry, ovf, menor, menor_u},
            {58'd0, e.zero, e.neg, e.carry, e.ovf, e.menor, e.menor_u});
      end
    end
  end

  task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dr);
    a = da; b = db; resta = dr; Y = dr ? da - db : da + db; in_valid = 1'b1;
  endtask

  // Present one input and hold until it is accepted (bounded)
  task automatic send(input logic [31:0] da, input logic [31:0] db, input logic dr);
    bit done = 0;
    drive(da, db, dr);
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, resta, Y));
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    n_out = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit saw_drop;
    int sent;
    rst = 1'b1; a = '0; b = '0; Y = '0; resta = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_cuenta", cuenta, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Add: 15 + 10, one-cycle latency
    send(32'd15, 32'd10, 1'b0);
    chk("add_valid", out_valid, 1);
    chk("add_res", res, 25);
    chk("add_flags", {zero, neg, carry, ovf, menor, menor_u}, 6'b000000);
    @(posedge clk); #1;
    chk("add_cuenta", cuenta, 1);

    send(32'd15, 32'd10, 1'b1);
    chk("sub_pos_res", res, 5);
    chk("sub_pos_flags", {carry, menor, menor_u}, 3'b100);

    send(32'd10, 32'd15, 1'b1);
    chk("sub_neg_res", res, 32'hFFFFFFFB);
    chk("sub_neg_flags", {zero, neg, carry, menor, menor_u}, 5'b01011);

    send(32'h7FFFFFFF, 32'd1, 1'b0);
    chk("add_ovf_flags", {ovf, neg, carry}, 3'b110);

    send(32'h80000000, 32'd1, 1'b1);
    chk("sub_ovf_res", res, 32'h7FFFFFFF);
    chk("sub_ovf_flags", {ovf, menor, menor_u}, 3'b110);

    send(32'h1234, 32'h1234, 1'b1);
    chk("sub_zero_flags", {zero, carry}, 2'b11);

    send(32'hFFFFFFFF, 32'd1, 1'b0);
    send(32'd3, 32'hFFFFFFFF, 1'b1);
    wait_drain();
    chk("cuenta_directed", cuenta, 8);

    // Backpressure stream 1..6 with out_ready low for cycles 2-4
    do_reset();
    saw_drop = 0; sent = 0;
    for (int c = 1; c <= 40; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      if (sent < 6) drive(sent + 1, 32'd0, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (!in_ready) saw_drop = 1;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, resta, Y));
        sent++;
      end
      if (c == 3) chk("bp_hold_res", res, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_in_ready_dropped", saw_drop, 1);
    chk("bp_sent", sent, 6);
    wait_drain();
    chk("bp_out_count", n_out, 6);
    chk("bp_cuenta", cuenta, 6);

    // Reset with both entries full
    out_ready = 1'b0;
    send(32'd8, 32'd0, 1'b0);
    send(32'd9, 32'd0, 1'b0);
    chk("full_in_ready", in_ready, 0);
    rst = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cuenta", cuenta, 0);
    chk("midrst_res", res, 0);
    exp_q.delete();
    @(posedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(32'd7, 32'd0, 1'b0);
    chk("post_rst_res", res, 7);
    wait_drain();
    chk("post_rst_cuenta", cuenta, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
